// File: rtl/sc_bitstream_gen.sv
// -----------------------------------------------------------------------------
// sc_bitstream_gen
//
// Stochastic number generator for the split-unipolar stochastic datapath.
// A load latches a pair of binary magnitudes (positive and negative channel).
// The block then emits LENGTH Bernoulli bits per channel, one bit per clock.
// Each bit is the unsigned compare (r <= value). The random source r comes
// from a free-running Galois LFSR: the positive channel uses it directly and
// the negative channel uses it bit-reversed. LENGTH = 2^WIDTH-1 walks the
// whole LFSR period, so each stream carries exactly `value` ones whatever
// the LFSR phase is at load.
//
// State table
//   state | meaning
//   IDLE  | ready for a load; registered outputs held at 0
//   RUN   | emitting one bit per clock; count tracks bits issued
//
// Ports
//   CLK        in   1      clock, rising edge
//   nRST       in   1      asynchronous active-low reset
//   load       in   1      start request, accepted when load && ready
//   value_pos  in   WIDTH  positive-channel magnitude, sampled on accept
//   value_neg  in   WIDTH  negative-channel magnitude, sampled on accept
//   ready      out  1      idle and able to accept load
//   y_pos      out  1      positive-channel stream bit (registered)
//   y_neg      out  1      negative-channel stream bit (registered)
//   valid      out  1      y_pos/y_neg carry a stream bit (registered)
//   done       out  1      pulse coincident with the last valid bit
// -----------------------------------------------------------------------------
module sc_bitstream_gen #(
  parameter int               WIDTH  = 8,
  parameter logic [WIDTH-1:0] POLY   = 8'hB8,
  parameter logic [WIDTH-1:0] SEED   = 8'h5A,
  parameter int               LENGTH = 255
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             load,
  input  logic [WIDTH-1:0] value_pos,
  input  logic [WIDTH-1:0] value_neg,
  output logic             ready,
  output logic             y_pos,
  output logic             y_neg,
  output logic             valid,
  output logic             done
);

  localparam int            CW   = $clog2(LENGTH + 1);
  localparam logic [CW-1:0] LAST = CW'(LENGTH - 1);

  // An all-zero seed locks the LFSR at zero, and a zero-length stream has no
  // bit for done to land on; both are rejected at elaboration.
  if (SEED == '0) begin : g_bad_seed
    $error("sc_bitstream_gen: SEED must be nonzero");
  end
  if (LENGTH < 1) begin : g_bad_length
    $error("sc_bitstream_gen: LENGTH must be >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [WIDTH-1:0] val_pos_q, val_pos_d;
  logic [WIDTH-1:0] val_neg_q, val_neg_d;
  logic             y_pos_q, y_pos_d;
  logic             y_neg_q, y_neg_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic [WIDTH-1:0] r_pos;
  logic [WIDTH-1:0] r_neg;

  // ---------------------------------------------------------------------------
  // Random source. The LFSR advances on every edge in every state, so the
  // phase at load is arbitrary; a full-period stream does not depend on it.
  // ---------------------------------------------------------------------------
  always_comb begin
    lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? POLY : '0);
  end

  // Reversing the bit order gives the negative channel a different
  // permutation of the same values, which decorrelates the two streams.
  always_comb begin
    r_pos = lfsr_q;
    r_neg = '0;
    for (int i = 0; i < WIDTH; i++) begin
      r_neg[i] = lfsr_q[WIDTH-1-i];
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM, next-state and registered-output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    val_pos_d = val_pos_q;
    val_neg_d = val_neg_q;
    y_pos_d   = 1'b0;
    y_neg_d   = 1'b0;
    valid_d   = 1'b0;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        // In IDLE, ready is high, so load alone is an accept.
        if (load) begin
          val_pos_d = value_pos;
          val_neg_d = value_neg;
          count_d   = '0;
          state_d   = RUN;
        end
      end

      RUN: begin
        y_pos_d = (r_pos <= val_pos_q);
        y_neg_d = (r_neg <= val_neg_q);
        valid_d = 1'b1;
        count_d = count_q + CW'(1);
        // Going to IDLE on the last bit raises ready while that bit is
        // visible. A load then can be accepted on the next edge, leaving a
        // single valid=0 bubble between streams.
        if (count_q == LAST) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      lfsr_q    <= SEED;
      count_q   <= '0;
      val_pos_q <= '0;
      val_neg_q <= '0;
      y_pos_q   <= 1'b0;
      y_neg_q   <= 1'b0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      count_q   <= count_d;
      val_pos_q <= val_pos_d;
      val_neg_q <= val_neg_d;
      y_pos_q   <= y_pos_d;
      y_neg_q   <= y_neg_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign y_pos = y_pos_q;
  assign y_neg = y_neg_q;
  assign valid = valid_q;
  assign done  = done_q;

endmodule

// File: tb/tb_sc_bitstream_gen.sv
// -----------------------------------------------------------------------------
// Testbench for sc_bitstream_gen. Uses directed vectors with hand-computed
// ones counts, a reference LFSR for per-bit expectations, and hand-written
// sequences for ignored loads, mid-stream reset and back-to-back streams.
// -----------------------------------------------------------------------------
module tb_sc_bitstream_gen;

  localparam int         WIDTH  = 8;
  localparam int         LENGTH = 255;
  localparam logic [7:0] POLY   = 8'hB8;
  localparam logic [7:0] SEED   = 8'h5A;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       load;
  logic [7:0] value_pos;
  logic [7:0] value_neg;
  logic       ready, y_pos, y_neg, valid, done;

  int checks = 0;
  int errors = 0;

  sc_bitstream_gen #(
    .WIDTH (WIDTH),
    .POLY  (POLY),
    .SEED  (SEED),
    .LENGTH(LENGTH)
  ) dut (
    .CLK      (CLK),
    .nRST     (nRST),
    .load     (load),
    .value_pos(value_pos),
    .value_neg(value_neg),
    .ready    (ready),
    .y_pos    (y_pos),
    .y_neg    (y_neg),
    .valid    (valid),
    .done     (done)
  );

  always #5 CLK = ~CLK;

  // Reference LFSR. m_prev holds the value the DUT used at the most recent
  // edge, which is the value behind the bit visible after that edge.
  logic [7:0] m_lfsr, m_prev;
  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      m_lfsr = SEED;
      m_prev = SEED;
    end else begin
      m_prev = m_lfsr;
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? POLY : 8'h00);
    end
  end

  function automatic logic [7:0] rev8(input logic [7:0] x);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = x[7-i];
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0] vp;
    logic [7:0] vn;
    int         exp_pos;
    int         exp_neg;
  } vec_t;

  // Runs one stream. inj_at > 0 pulses a load (value_pos = 200) once bit
  // inj_at is visible. rst_at > 0 asserts reset once bit rst_at is visible.
  task automatic run_stream(input string tag, input logic [7:0] vp,
                            input logic [7:0] vn, input int exp_p,
                            input int exp_n, input int inj_at,
                            input int rst_at);
    int n, op, on, dn, dpos, bad;
    n = 0; op = 0; on = 0; dn = 0; dpos = -1; bad = 0;
    @(negedge CLK);
    chk({tag, "_ready_idle"}, int'(ready), 1);
    value_pos = vp;
    value_neg = vn;
    load      = 1'b1;
    @(negedge CLK);
    load = 1'b0;
    chk({tag, "_ready_drop"}, int'(ready), 0);
    value_pos = ~vp;
    value_neg = ~vn;
    for (int cyc = 0; cyc < LENGTH + 10; cyc++) begin
      @(negedge CLK);
      load = 1'b0;
      if (valid) begin
        n++;
        op += int'(y_pos);
        on += int'(y_neg);
        if (y_pos !== (m_prev <= vp) || y_neg !== (rev8(m_prev) <= vn)) bad++;
      end
      if (done) begin
        dn++;
        dpos = n;
        chk({tag, "_ready_at_done"}, int'(ready), 1);
        break;
      end
      if (inj_at > 0 && n == inj_at) begin
        value_pos = 8'd200;
        load      = 1'b1;
      end
      if (rst_at > 0 && n == rst_at) begin
        #2 nRST = 1'b0;
        #1;
        chk({tag, "_rst_outs"}, int'({y_pos, y_neg, valid, done}), 0);
        chk({tag, "_rst_ready"}, int'(ready), 1);
        for (int k = 0; k < 3; k++) begin
          @(negedge CLK);
          dn += int'(done);
          bad += int'(valid);
        end
        nRST = 1'b1;
        chk({tag, "_rst_no_done"}, dn, 0);
        chk({tag, "_rst_no_valid"}, bad, 0);
        return;
      end
    end
    chk({tag, "_nbits"}, n, LENGTH);
    chk({tag, "_done_cnt"}, dn, 1);
    chk({tag, "_done_pos"}, dpos, LENGTH);
    chk({tag, "_ones_pos"}, op, exp_p);
    chk({tag, "_ones_neg"}, on, exp_n);
    chk({tag, "_bit_errs"}, bad, 0);
    @(negedge CLK);
    chk({tag, "_bubble"}, int'(valid), 0);
    chk({tag, "_done_clear"}, int'(done), 0);
  endtask

  vec_t vecs[5];

  initial begin
    vecs[0] = '{vp: 8'd0,   vn: 8'd255, exp_pos: 0,   exp_neg: 255};
    vecs[1] = '{vp: 8'd100, vn: 8'd37,  exp_pos: 100, exp_neg: 37};
    vecs[2] = '{vp: 8'd255, vn: 8'd0,   exp_pos: 255, exp_neg: 0};
    vecs[3] = '{vp: 8'd1,   vn: 8'd254, exp_pos: 1,   exp_neg: 254};
    vecs[4] = '{vp: 8'd128, vn: 8'd128, exp_pos: 128, exp_neg: 128};

    nRST      = 1'b0;
    load      = 1'b0;
    value_pos = 8'd0;
    value_neg = 8'd0;

    // Reset held: load toggling must not disturb anything.
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      load = ~load;
      #1;
      chk("rst_outs", int'({y_pos, y_neg, valid, done}), 0);
      chk("rst_ready", int'(ready), 1);
    end
    chk("rst_lfsr", int'(dut.lfsr_q), 'h5A);
    @(negedge CLK);
    load = 1'b0;
    nRST = 1'b1;
    chk("lfsr_0", int'(dut.lfsr_q), 'h5A);
    @(negedge CLK);
    chk("lfsr_1", int'(dut.lfsr_q), 'h2D);
    @(negedge CLK);
    chk("lfsr_2", int'(dut.lfsr_q), 'hAE);

    for (int i = 0; i < 5; i++) begin
      run_stream($sformatf("vec%0d", i), vecs[i].vp, vecs[i].vn,
                 vecs[i].exp_pos, vecs[i].exp_neg, 0, 0);
    end

    run_stream("ign_load", 8'd100, 8'd37, 100, 37, 10, 0);
    run_stream("mid_rst", 8'd100, 8'd37, 100, 37, 0, 50);
    run_stream("after_rst", 8'd100, 8'd37, 100, 37, 0, 0);

    // load held high: streams repeat with a single bubble between them.
    begin
      int w, len, d, op, gap;
      @(negedge CLK);
      value_pos = 8'd100;
      value_neg = 8'd37;
      load      = 1'b1;
      w = 0;
      while (!valid && w < 10) begin
        @(negedge CLK);
        w++;
      end
      chk("hold_first_valid", int'(valid), 1);
      for (int s = 0; s < 3; s++) begin
        len = 0; d = 0; op = 0;
        while (valid && len < 300) begin
          len++;
          d  += int'(done);
          op += int'(y_pos);
          @(negedge CLK);
        end
        chk($sformatf("hold%0d_len", s), len, LENGTH);
        chk($sformatf("hold%0d_done", s), d, 1);
        chk($sformatf("hold%0d_ones", s), op, 100);
        if (s < 2) begin
          gap = 0;
          while (!valid && gap < 10) begin
            gap++;
            @(negedge CLK);
          end
          chk($sformatf("hold%0d_gap", s), gap, 1);
        end
      end
      load = 1'b0;
      w = 0;
      while (!ready && w < 300) begin
        @(negedge CLK);
        w++;
      end
      chk("hold_drain_ready", int'(ready), 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
